// File: rtl/dmem_pkg.sv
// Shared constants for the data memory: MMIO register offsets and fault bit layout.
// Also holds the sticky-fault update rule used wherever the Fault register lives.
package dmem_pkg;

  localparam int FAULT_W    = 2;
  localparam int F_MISALIGN = 0;
  localparam int F_RANGE    = 1;

  localparam logic [3:0] OFF_OUT  = 4'h0;
  localparam logic [3:0] OFF_CYC  = 4'h4;
  localparam logic [3:0] OFF_STAT = 4'h8;

  // A newly detected fault wins over a write-1-to-clear in the same cycle.
  function automatic logic [FAULT_W-1:0] fault_next(
    input logic [FAULT_W-1:0] cur,
    input logic [FAULT_W-1:0] clr,
    input logic [FAULT_W-1:0] set
  );
    return (cur & ~clr) | set;
  endfunction

endpackage

// File: rtl/dmem_mmio_regs.sv
// Memory-mapped OUT / CYC / STAT registers of data_mem; built only with DMEM_MMIO_EN.
// Holds the sticky Fault flags so that STAT writes can clear them.
`ifdef DMEM_MMIO_EN
module dmem_mmio_regs
  import dmem_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sel,
  input  logic               mem_write,
  input  logic [31:0]        wd,
  input  logic [3:0]         offset,
  input  logic [FAULT_W-1:0] fault_set,
  output logic [31:0]        rdata,
  output logic [31:0]        io_out,
  output logic [FAULT_W-1:0] fault
);

  logic [31:0]        out_q;
  logic [31:0]        cyc_q;
  logic [FAULT_W-1:0] fault_q;
  logic               wr_out;
  logic               wr_cyc;
  logic               wr_stat;
  logic [FAULT_W-1:0] fault_clr;

  always_comb begin
    wr_out    = sel && mem_write && (offset == OFF_OUT);
    wr_cyc    = sel && mem_write && (offset == OFF_CYC);
    wr_stat   = sel && mem_write && (offset == OFF_STAT);
    fault_clr = wr_stat ? wd[FAULT_W-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      cyc_q   <= '0;
      fault_q <= '0;
    end else begin
      if (wr_out) out_q <= wd;
      // A software load of CYC replaces this edge's increment.
      cyc_q   <= wr_cyc ? wd : cyc_q + 32'd1;
      fault_q <= fault_next(fault_q, fault_clr, fault_set);
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_OUT:  rdata = out_q;
      OFF_CYC:  rdata = cyc_q;
      OFF_STAT: rdata = {{(32-FAULT_W){1'b0}}, fault_q};
      default:  rdata = '0;
    endcase
  end

  assign io_out = out_q;
  assign fault  = fault_q;

endmodule
`endif

// File: rtl/data_mem.sv
// Word-addressed data memory with combinational load, clocked store and sticky faults.
// Define DMEM_MMIO_EN to add the 16-byte MMIO window (OUT, CYC, STAT) at IO_BASE.
module data_mem
  import dmem_pkg::*;
#(
  parameter int          DEPTH   = 64,
  parameter logic [31:0] IO_BASE = 32'hFFFF_0000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               MemWrite,
  input  logic               MemRead,
  input  logic [31:0]        A,
  input  logic [31:0]        WD,
  output logic [31:0]        ReadData,
  output logic [31:0]        IO_Out,
  output logic [FAULT_W-1:0] Fault
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]        mem [DEPTH];
  logic               access;
  logic               misaligned;
  logic               in_ram;
  logic               in_io;
  logic               ram_we;
  logic [AW-1:0]      index;
  logic [FAULT_W-1:0] fault_set;

  always_comb begin
    access     = MemRead || MemWrite;
    misaligned = (A[1:0] != 2'b00);
    in_ram     = (A[31:AW+2] == '0);
    index      = A[AW+1:2];
    ram_we     = MemWrite && !misaligned && in_ram;
  end

`ifdef DMEM_MMIO_EN
  logic [31:0] io_rdata;

  assign in_io = (A[31:4] == IO_BASE[31:4]);

  dmem_mmio_regs u_mmio (
    .clk       (CLK),
    .rst_n     (RST),
    .sel       (in_io && !misaligned),
    .mem_write (MemWrite),
    .wd        (WD),
    .offset    (A[3:0]),
    .fault_set (fault_set),
    .rdata     (io_rdata),
    .io_out    (IO_Out),
    .fault     (Fault)
  );
`else
  logic               unused_io_base;
  logic [FAULT_W-1:0] fault_q;

  assign unused_io_base = ^IO_BASE;
  assign in_io          = 1'b0;
  assign IO_Out         = '0;
  assign Fault          = fault_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) fault_q <= '0;
    else      fault_q <= fault_next(fault_q, '0, fault_set);
  end
`endif

  // Misalignment takes priority, so a misaligned out-of-range access flags only bit 0.
  always_comb begin
    fault_set             = '0;
    fault_set[F_MISALIGN] = access && misaligned;
    fault_set[F_RANGE]    = access && !misaligned && !in_ram && !in_io;
  end

  // A store held across an edge while reset is low is discarded; contents are never cleared.
  always_ff @(posedge CLK or negedge RST) begin
    if (RST && ram_we) mem[index] <= WD;
  end

  always_comb begin
    ReadData = '0;
    if (access && misaligned) begin
      ReadData = '0;
    end else if (in_ram) begin
      ReadData = mem[index];
`ifdef DMEM_MMIO_EN
    end else if (in_io) begin
      ReadData = io_rdata;
`endif
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios followed by random traffic,
// all checked against a word-level reference model of the memory, MMIO and faults.
module tb_data_mem;

  localparam int          DEPTH   = 64;
  localparam logic [31:0] IO_BASE = 32'hFFFF_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MemRead  = 1'b0;
  logic [31:0] A  = '0;
  logic [31:0] WD = '0;
  logic [31:0] ReadData;
  logic [31:0] IO_Out;
  logic [1:0]  Fault;

  int n_asserts = 0;
  int n_fails   = 0;

  // Reference model state
  logic [31:0] m_mem   [DEPTH];
  bit          m_valid [DEPTH];
  logic [1:0]  m_fault = 2'b00;
  logic [31:0] m_out   = '0;
  logic [31:0] m_cyc   = '0;
`ifdef DMEM_MMIO_EN
  bit          m_mmio  = 1'b1;
`else
  bit          m_mmio  = 1'b0;
`endif

  data_mem #(.DEPTH(DEPTH), .IO_BASE(IO_BASE)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .A        (A),
    .WD       (WD),
    .ReadData (ReadData),
    .IO_Out   (IO_Out),
    .Fault    (Fault)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return m_mmio && (a >= IO_BASE) && ({1'b0, a} < {1'b0, IO_BASE} + 33'd16);
  endfunction

  // Expected load value from the model's pre-edge state; known=0 for never-written RAM.
  function automatic logic [31:0] model_read(input logic [31:0] a, input bit acc, output bit known);
    logic [31:0] off;
    known = 1'b1;
    if (acc && a[1:0] != 2'b00) return '0;
    if (a < 32'(DEPTH * 4)) begin
      known = m_valid[a / 4];
      return m_mem[a / 4];
    end
    if (in_window(a)) begin
      off = a - IO_BASE;
      if (off == 32'h0) return m_out;
      if (off == 32'h4) return m_cyc;
      if (off == 32'h8) return {30'b0, m_fault};
      return '0;
    end
    return '0;
  endfunction

  // Model of one clock edge.
  task automatic model_edge(input bit we, input bit re, input logic [31:0] a, input logic [31:0] wd);
    bit          acc, mis, ram, io;
    logic [1:0]  set, clr;
    logic [31:0] off;
    acc = we || re;
    mis = (a[1:0] != 2'b00);
    ram = (a < 32'(DEPTH * 4));
    io  = in_window(a);
    off = a - IO_BASE;
    set = {acc && !mis && !ram && !io, acc && mis};
    clr = 2'b00;
    if (we && !mis && ram) begin
      m_mem[a / 4]   = wd;
      m_valid[a / 4] = 1'b1;
    end
    if (m_mmio) begin
      if (we && !mis && io && off == 32'h0) m_out = wd;
      if (we && !mis && io && off == 32'h4) m_cyc = wd;
      else m_cyc = m_cyc + 32'd1;
      if (we && !mis && io && off == 32'h8) clr = wd[1:0];
    end
    m_fault = (m_fault & ~clr) | set;
  endtask

  // Called at posedge+1: drive, check load, cross the edge, check registers.
  task automatic do_cycle(input bit we, input bit re, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
    bit          known;
    logic [31:0] exp_rd;
    MemWrite = we; MemRead = re; A = a; WD = wd;
    #3;
    exp_rd = model_read(a, we || re, known);
    if (known) chk({tag, "/read"}, ReadData, exp_rd);
    @(posedge CLK);
    model_edge(we, re, a, wd);
    #1;
    chk({tag, "/fault"}, {30'b0, Fault}, {30'b0, m_fault});
    chk({tag, "/io_out"}, IO_Out, m_out);
  endtask

  initial begin
    bit          we, re;
    int          kind;
    logic [31:0] a;

    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;

    // Power-on reset
    #2;
    chk("reset/fault", {30'b0, Fault}, 32'h0);
    chk("reset/io_out", IO_Out, 32'h0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b1;

    // Store then load
    do_cycle(1, 0, 32'h8, 32'hDEAD_BEEF, "sw8");
    do_cycle(0, 1, 32'h8, 32'h0, "lw8");
    chk("lw8/direct", ReadData, 32'hDEAD_BEEF);

    // Read during the store cycle returns old data
    do_cycle(1, 0, 32'h8, 32'h1, "sw8_1");
    do_cycle(1, 1, 32'h8, 32'h2, "sw8_2_old");
    do_cycle(0, 1, 32'h8, 32'h0, "lw8_new");

    // Misaligned store leaves RAM alone and sets sticky bit 0
    do_cycle(1, 0, 32'h4, 32'h1111_1111, "sw4");
    do_cycle(1, 0, 32'h6, 32'h9999_9999, "sw6_mis");
    chk("mis/fault", {30'b0, Fault}, 32'h1);
    for (int i = 0; i < 5; i++) do_cycle(0, 0, 32'h0, 32'h0, "idle_sticky");
    do_cycle(0, 1, 32'h4, 32'h0, "lw4_unchanged");
    chk("mis/ram", ReadData, 32'h1111_1111);

    // Misaligned and out of range: only bit 0; idle at out-of-range: nothing
    do_cycle(0, 1, 32'h101, 32'h0, "lw101_mis_oor");
    do_cycle(0, 0, 32'h100, 32'h0, "idle_oor");
    chk("idle_oor/fault", {30'b0, Fault}, 32'h1);
    do_cycle(0, 1, 32'h100, 32'h0, "lw100_oor");
    chk("oor/fault", {30'b0, Fault}, 32'h3);

`ifdef DMEM_MMIO_EN
    do_cycle(1, 0, IO_BASE + 32'h0, 32'h5A, "wr_out");
    chk("mmio/io_out", IO_Out, 32'h5A);
    do_cycle(1, 0, IO_BASE + 32'h4, 32'hFFFF_FFFE, "wr_cyc");
    for (int i = 0; i < 3; i++) do_cycle(0, 1, IO_BASE + 32'h4, 32'h0, "rd_cyc");
    do_cycle(0, 1, IO_BASE + 32'h8, 32'h0, "rd_stat");
    do_cycle(1, 0, IO_BASE + 32'h9, 32'h3, "wr_stat_mis");
    chk("stat_mis/fault", {30'b0, Fault}, 32'h3);
    do_cycle(1, 0, IO_BASE + 32'h8, 32'h3, "wr_stat_clr");
    chk("stat_clr/fault", {30'b0, Fault}, 32'h0);
    do_cycle(1, 1, IO_BASE + 32'hC, 32'h7, "wr_rsvd");
    do_cycle(0, 1, IO_BASE + 32'hC, 32'h0, "rd_rsvd");
`endif

    // Reset asserted in the middle of a store held across the edge
    MemWrite = 1'b1; MemRead = 1'b0; A = 32'h8; WD = 32'h0BAD_0BAD;
    #2 RST = 1'b0;
    #1;
    chk("midrst/fault", {30'b0, Fault}, 32'h0);
    chk("midrst/io_out", IO_Out, 32'h0);
    @(posedge CLK);
    #1 RST = 1'b1;
    MemWrite = 1'b0;
    m_fault = 2'b00; m_out = '0; m_cyc = '0;
    do_cycle(0, 1, 32'h8, 32'h0, "midrst_lost");
    chk("midrst/ram", ReadData, 32'h2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, DEPTH - 1)) * 4;
      case (kind)
        6: begin
          a = a + 32'($urandom_range(1, 3));
          if (!we && !re) re = 1'b1;
        end
        7: a = $urandom_range(DEPTH * 4, 32'h7FFF_FFFF);
        8: begin
          if (m_mmio) a = IO_BASE + 32'($urandom_range(0, 15));
          else        a = $urandom_range(DEPTH * 4, 32'h7FFF_FFFF);
          if (a[1:0] != 2'b00 && !we && !re) re = 1'b1;
        end
        9: begin we = 1'b0; re = 1'b0; end
        default: ;
      endcase
      do_cycle(we, re, a, $urandom, "rand");
    end

    MemWrite = 1'b0; MemRead = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
